// File: rtl/idt_pkg.sv
// Shared types and helpers for the instruction dependency table / issue scheduler.
package idt_pkg;

  localparam int unsigned MAX_BS    = 64;
  localparam int unsigned MAX_IDX_W = 6;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_ISSUED = 2'd3
  } entry_st_e;

  function automatic int unsigned idx_w(input int unsigned bs);
    return (bs < 2) ? 1 : $clog2(bs);
  endfunction

  function automatic logic [MAX_BS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return MAX_BS'(1) << idx;
  endfunction

  // Lifecycle state of one entry derived from its valid/issued bits and row
  function automatic entry_st_e entry_state(input logic valid, input logic issued,
                                            input logic deps_zero);
    if (!valid)     return ST_FREE;
    if (issued)     return ST_ISSUED;
    if (!deps_zero) return ST_WAIT;
    return ST_READY;
  endfunction

endpackage

// File: rtl/idt_prio_enc.sv
// Find-first-set over a request vector; the lowest set index wins.
module idt_prio_enc #(
  parameter int unsigned BS    = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [BS-1:0]    req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = int'(BS) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/idt_issue_scheduler.sv
// Dependency table with per-entry valid/issued state, completion wakeup and a
// lowest-index valid/ready issue port.
module idt_issue_scheduler
  import idt_pkg::*;
#(
  parameter int unsigned BS    = 16,
  parameter int unsigned IDX_W = idx_w(BS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_index,
  input  logic [BS-1:0]    alloc_deps,
  output logic             alloc_err,
  input  logic             cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_index,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_index,
  input  logic             issue_ready,
  input  logic             flush,
  output logic [IDX_W:0]   count,
  output logic             full
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [BS-1:0]    rows_q [BS];
  logic [BS-1:0]    rows_d [BS];
  logic [BS-1:0]    valid_q, valid_d;
  logic [BS-1:0]    issued_q, issued_d;
  logic             issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0] issue_index_q, issue_index_d;
  logic             alloc_err_q, alloc_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  logic [BS-1:0]    cmpl_oh, alloc_oh, offer_oh;
  logic [BS-1:0]    completing, live, alloc_row;
  logic [BS-1:0]    ready_vec, cand;
  logic             hs, alloc_ok, offer_cmpl, upd;
  logic [IDX_W-1:0] pe_idx;
  logic             pe_any;

  // Event decode; "live" is the valid set after this cycle's completion
  always_comb begin
    cmpl_oh    = BS'(onehot(MAX_IDX_W'(cmpl_index)));
    alloc_oh   = BS'(onehot(MAX_IDX_W'(alloc_index)));
    offer_oh   = BS'(onehot(MAX_IDX_W'(issue_index_q)));
    completing = cmpl_valid ? (cmpl_oh & valid_q) : '0;
    live       = valid_q & ~completing;
    alloc_ok   = alloc_valid & ~live[alloc_index];
    alloc_row  = alloc_deps & live & ~alloc_oh;
    hs         = issue_valid_q & issue_ready;
    offer_cmpl = issue_valid_q & (|(offer_oh & completing));
    upd        = ~issue_valid_q | issue_ready | offer_cmpl;
  end

  always_comb begin
    for (int i = 0; i < int'(BS); i++) begin
      ready_vec[i] = (entry_state(valid_q[i], issued_q[i], rows_q[i] == '0) == ST_READY);
    end
    cand = ready_vec & ~completing & ~(hs ? offer_oh : '0);
  end

  idt_prio_enc #(
    .BS    (BS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req_i (cand),
    .idx_o (pe_idx),
    .any_o (pe_any)
  );

  // Next state: flush > complete > alloc > issue mark
  always_comb begin
    for (int i = 0; i < int'(BS); i++) begin
      rows_d[i] = rows_q[i] & ~completing;
      if (alloc_ok && alloc_oh[i]) rows_d[i] = alloc_row;
    end
    valid_d       = live | (alloc_ok ? alloc_oh : '0);
    issued_d      = issued_q & ~completing;
    alloc_err_d   = alloc_err_q | (alloc_valid & ~alloc_ok);
    issue_valid_d = issue_valid_q;
    issue_index_d = issue_index_q;

    // A freed (or freed-and-reallocated) slot must not inherit the issue mark
    if (hs && live[issue_index_q]) issued_d = issued_d | offer_oh;

    if (upd) begin
      issue_valid_d = pe_any;
      issue_index_d = pe_idx;
    end

    if (flush) begin
      for (int i = 0; i < int'(BS); i++) rows_d[i] = '0;
      valid_d       = '0;
      issued_d      = '0;
      alloc_err_d   = alloc_err_q;
      issue_valid_d = 1'b0;
      issue_index_d = '0;
    end

    count_d = '0;
    for (int i = 0; i < int'(BS); i++) count_d = count_d + CNT_W'(valid_d[i]);
    full_d = (count_d == CNT_W'(BS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BS); i++) rows_q[i] <= '0;
      valid_q       <= '0;
      issued_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      alloc_err_q   <= 1'b0;
      count_q       <= '0;
      full_q        <= 1'b0;
    end else begin
      for (int i = 0; i < int'(BS); i++) rows_q[i] <= rows_d[i];
      valid_q       <= valid_d;
      issued_q      <= issued_d;
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      alloc_err_q   <= alloc_err_d;
      count_q       <= count_d;
      full_q        <= full_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_index = issue_index_q;
  assign alloc_err   = alloc_err_q;
  assign count       = count_q;
  assign full        = full_q;

endmodule

// File: tb/tb_idt_issue_scheduler.sv
// Directed bench for idt_issue_scheduler with an expected-issue-order scoreboard.
module tb_idt_issue_scheduler;

  localparam int unsigned BS    = 16;
  localparam int unsigned IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_index;
  logic [BS-1:0]    alloc_deps;
  logic             alloc_err;
  logic             cmpl_valid;
  logic [IDX_W-1:0] cmpl_index;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_index;
  logic             issue_ready;
  logic             flush;
  logic [IDX_W:0]   count;
  logic             full;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  idt_issue_scheduler #(.BS(BS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_index (alloc_index),
    .alloc_deps  (alloc_deps),
    .alloc_err   (alloc_err),
    .cmpl_valid  (cmpl_valid),
    .cmpl_index  (cmpl_index),
    .issue_valid (issue_valid),
    .issue_index (issue_index),
    .issue_ready (issue_ready),
    .flush       (flush),
    .count       (count),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the current offer against the oldest expected issue index
  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=scoreboard_empty expected=pending_entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
      chk({tag, "_index"}, 32'(issue_index), 32'(e));
    end
  endtask

  task automatic alloc(input int idx, input logic [BS-1:0] deps);
    alloc_valid = 1'b1;
    alloc_index = IDX_W'(idx);
    alloc_deps  = deps;
    tick();
    alloc_valid = 1'b0;
    alloc_deps  = '0;
  endtask

  task automatic cmpl(input int idx);
    cmpl_valid = 1'b1;
    cmpl_index = IDX_W'(idx);
    tick();
    cmpl_valid = 1'b0;
  endtask

  task automatic accept();
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_index = '0;
    alloc_deps  = '0;
    cmpl_valid  = 1'b0;
    cmpl_index  = '0;
    issue_ready = 1'b0;
    flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_index", 32'(issue_index), 32'd0);
    chk("rst_alloc_err",   32'(alloc_err),   32'd0);
    chk("rst_count",       32'(count),       32'd0);
    chk("rst_full",        32'(full),        32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-dep alloc is offered one edge later, then issued
    alloc(3, 16'h0000);
    chk("t1_latency", 32'(issue_valid), 32'd0);
    exp_q.push_back(3);
    tick();
    pop_check("t1_offer");
    accept();
    chk("t1_issued_bit", 32'(dut.issued_q[3]), 32'd1);
    chk("t1_offer_gone", 32'(issue_valid), 32'd0);
    chk("t1_count",      32'(count),       32'd1);
    cmpl(3);
    chk("t1_freed", 32'(count), 32'd0);

    // Completion wakeup
    alloc(0, 16'h0000);
    alloc(1, 16'h0001);
    exp_q.push_back(0);
    pop_check("t2_offer0");
    chk("t2_row1", 32'(dut.rows_q[1]), 32'h1);
    cmpl(0);
    chk("t2_row1_cleared", 32'(dut.rows_q[1]), 32'h0);
    chk("t2_offer0_dropped", 32'(issue_valid), 32'd0);
    exp_q.push_back(1);
    tick();
    pop_check("t2_wake1");
    accept();
    cmpl(1);
    chk("t2_count", 32'(count), 32'd0);

    // Hold under backpressure, then back-to-back issue in index order
    alloc(2, 16'h0000);
    alloc(5, 16'h0000);
    alloc(9, 16'h0000);
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(9);
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_valid", 32'(issue_valid), 32'd1);
      chk("t3_hold_index", 32'(issue_index), 32'd2);
      tick();
    end
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pop_check("t3_b2b");
      tick();
    end
    issue_ready = 1'b0;
    chk("t3_drained", 32'(issue_valid), 32'd0);
    chk("t3_count",   32'(count),       32'd3);
    cmpl(2);
    cmpl(5);
    cmpl(9);
    chk("t3_freed", 32'(count), 32'd0);

    // Fill all slots, then hit an occupied slot
    for (int i = 0; i < int'(BS); i++) alloc(i, 16'h0000);
    chk("t4_count",    32'(count),     32'd16);
    chk("t4_full",     32'(full),      32'd1);
    chk("t4_err_pre",  32'(alloc_err), 32'd0);
    alloc(7, 16'hFFFF);
    chk("t4_err",      32'(alloc_err),      32'd1);
    chk("t4_row7",     32'(dut.rows_q[7]), 32'h0);
    chk("t4_count2",   32'(count),          32'd16);
    exp_q.push_back(0);
    pop_check("t4_offer");

    // Flush with an offer pending and a same-cycle alloc that must be ignored
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_index = IDX_W'(3);
    alloc_deps  = '0;
    tick();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    chk("t6_flush_valid", 32'(issue_valid), 32'd0);
    chk("t6_flush_count", 32'(count),       32'd0);
    chk("t6_flush_full",  32'(full),        32'd0);
    chk("t6_flush_err",   32'(alloc_err),   32'd1);

    // Same-cycle complete + realloc of slot 4 with a self dependency
    alloc(4, 16'h0000);
    exp_q.push_back(4);
    tick();
    pop_check("t5_first");
    accept();
    chk("t5_issued", 32'(dut.issued_q[4]), 32'd1);
    cmpl_valid  = 1'b1;
    cmpl_index  = IDX_W'(4);
    alloc_valid = 1'b1;
    alloc_index = IDX_W'(4);
    alloc_deps  = 16'h0010;
    tick();
    cmpl_valid  = 1'b0;
    alloc_valid = 1'b0;
    alloc_deps  = '0;
    chk("t5_count",      32'(count),            32'd1);
    chk("t5_row4",       32'(dut.rows_q[4]),    32'h0);
    chk("t5_not_issued", 32'(dut.issued_q[4]),  32'd0);
    chk("t5_latency",    32'(issue_valid),      32'd0);
    exp_q.push_back(4);
    tick();
    pop_check("t5_reoffer");
    alloc(8, 16'h0200);
    chk("t5_dead_dep",  32'(dut.rows_q[8]),  32'h0);
    alloc(10, 16'h0110);
    chk("t5_live_deps", 32'(dut.rows_q[10]), 32'h0110);
    chk("t5_count3",    32'(count),          32'd3);

    // Asynchronous reset mid-run takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    chk("t6_rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("t6_rst_issue_index", 32'(issue_index), 32'd0);
    chk("t6_rst_alloc_err",   32'(alloc_err),   32'd0);
    chk("t6_rst_count",       32'(count),       32'd0);
    chk("t6_rst_full",        32'(full),        32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst_count", 32'(count), 32'd0);
    chk("t6_post_rst_row10", 32'(dut.rows_q[10]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
